// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the conv layer scheduler.
// Timeout support is enabled by defining CONV_SCHED_TIMEOUT_EN.
package conv_sched_pkg;

    typedef enum logic [1:0] {
        eIDLE   = 2'd0,
        eSTREAM = 2'd1,
        eWAIT   = 2'd2,
        eDONE   = 2'd3
    } state_e;

    function automatic int frame_words(input int height, input int width);
        return height * width;
    endfunction

endpackage

// File: rtl/conv_layer_scheduler_up_counter_enabled.sv
// Saturation-free up counter with synchronous clear and enable.
// Width is sized so INPUT_MAX itself is representable.
module up_counter_enabled #(
    parameter int INPUT_MAX = 128
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           clear_i,
    input  logic                           en_i,
    output logic [$clog2(INPUT_MAX+1)-1:0] count_o
);

    localparam int W = $clog2(INPUT_MAX + 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (en_i)
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/conv_layer_scheduler.sv
// Frame sequencer for a bank of lockstep convolution kernels.
// Optional watchdog: define CONV_SCHED_TIMEOUT_EN.
module conv_layer_scheduler
    import conv_sched_pkg::*;
#(
    parameter int NUM_KERNELS        = 4,
    parameter int INPUT_LAYER_HEIGHT = 64,
    parameter int KERNEL_WIDTH       = 2,
    parameter int WORD_SIZE          = 16,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic signed [WORD_SIZE-1:0] data_i,
    output logic [NUM_KERNELS-1:0]      conv_start_o,
    output logic [NUM_KERNELS-1:0]      conv_valid_o,
    input  logic [NUM_KERNELS-1:0]      conv_ready_i,
    output logic signed [WORD_SIZE-1:0] conv_data_o,
    input  logic [NUM_KERNELS-1:0]      conv_valid_i,
    output logic [NUM_KERNELS-1:0]      conv_yumi_o,
    output logic                        valid_o,
    input  logic                        yumi_i,
    output logic                        busy_o,
    output logic                        error_o
);

    localparam int FRAME_WORDS =
        frame_words(INPUT_LAYER_HEIGHT, KERNEL_WIDTH);
    localparam int CW = $clog2(FRAME_WORDS + 1);

    state_e                 state_q;
    logic [NUM_KERNELS-1:0] mask_q;
    logic                   valid_q;
    logic                   busy_q;
    logic [CW-1:0]          count;

    logic                   all_ready;
    logic                   start_go;
    logic                   xfer;
    logic                   last_xfer;
    logic                   consume;
    logic [NUM_KERNELS-1:0] mask_all;
    logic                   frame_done;

`ifdef CONV_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
    logic            error_q;
`endif

    // Handshake strobes are gated by reset so a mid-frame reset
    // never leaks a start, valid or yumi pulse to the kernels.
    always_comb begin
        all_ready  = &conv_ready_i;
        start_go   = !reset_i && (state_q == eIDLE) && start_i;
        xfer       = !reset_i && (state_q == eSTREAM)
                     && valid_i && all_ready;
        last_xfer  = xfer && (count == CW'(FRAME_WORDS - 1));
        consume    = !reset_i && (state_q == eDONE) && yumi_i;
        mask_all   = mask_q | conv_valid_i;
        frame_done = &mask_all;
    end

    up_counter_enabled #(
        .INPUT_MAX(FRAME_WORDS)
    ) u_word_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(start_go || consume),
        .en_i   (xfer),
        .count_o(count)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= eIDLE;
            mask_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef CONV_SCHED_TIMEOUT_EN
            wd_q    <= '0;
            error_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                eIDLE: begin
                    if (start_i) begin
                        state_q <= eSTREAM;
                        mask_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                eSTREAM: begin
                    mask_q <= mask_all;
`ifdef CONV_SCHED_TIMEOUT_EN
                    wd_q   <= '0;
`endif
                    if (last_xfer)
                        state_q <= eWAIT;
                end
                eWAIT: begin
                    mask_q <= mask_all;
                    if (frame_done) begin
                        state_q <= eDONE;
                        valid_q <= 1'b1;
                    end
`ifdef CONV_SCHED_TIMEOUT_EN
                    else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q <= eDONE;
                        valid_q <= 1'b1;
                        error_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
`endif
                end
                eDONE: begin
                    if (yumi_i) begin
                        state_q <= eIDLE;
                        mask_q  <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign ready_o      = !reset_i && (state_q == eSTREAM) && all_ready;
    assign conv_start_o = {NUM_KERNELS{start_go}};
    assign conv_valid_o = {NUM_KERNELS{xfer}};
    assign conv_yumi_o  = {NUM_KERNELS{consume}};
    assign conv_data_o  = data_i;
    assign valid_o      = valid_q;
    assign busy_o       = busy_q;
`ifdef CONV_SCHED_TIMEOUT_EN
    assign error_o      = error_q;
`else
    assign error_o      = 1'b0;
`endif

endmodule

// File: doc/conv_layer_scheduler.md
Name: conv_layer_scheduler

Overview:
- Sequences a bank of NUM_KERNELS parallel convolution kernels that share one input sample stream.
- Issues the per-frame start pulse to every kernel.
- Broadcasts each input word to all kernels in lockstep, and only when every kernel is ready.
- Gathers the per-kernel done handshakes into a single valid/yumi handshake toward the next layer.
- Sits between the input sample source and the conv kernel bank. Kernel data buses go straight to the next layer; this block moves no data except the broadcast word.

Parameters:
- NUM_KERNELS, 4, number of convolution kernels controlled.
- INPUT_LAYER_HEIGHT, 64, input layer height.
- KERNEL_WIDTH, 2, channels per input row (2 = I/Q); frame length FRAME_WORDS = INPUT_LAYER_HEIGHT*KERNEL_WIDTH.
- WORD_SIZE, 16, bits per data word.
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with CONV_SCHED_TIMEOUT_EN).

Ports:
- clk_i  input  1  clock
- reset_i  input  1  synchronous, active-high reset
- start_i  input  1  request to begin a new frame
- valid_i  input  1  upstream word valid
- ready_o  output  1  upstream ready; high only when a word can be broadcast to all kernels
- data_i  input  WORD_SIZE  upstream word (signed)
- conv_start_o  output  NUM_KERNELS  one-cycle start pulse per kernel
- conv_valid_o  output  NUM_KERNELS  per-kernel input valid
- conv_ready_i  input  NUM_KERNELS  per-kernel input ready
- conv_data_o  output  WORD_SIZE  broadcast word, equal to data_i
- conv_valid_i  input  NUM_KERNELS  per-kernel output valid
- conv_yumi_o  output  NUM_KERNELS  per-kernel output yumi
- valid_o  output  1  all kernel outputs available
- yumi_i  input  1  downstream consumes outputs
- busy_o  output  1  high in any state except eIDLE
- error_o  output  1  watchdog error

Behaviour:
- States: eIDLE, eSTREAM, eWAIT, eDONE, held in a 2-bit enum.
- Reset: state goes to eIDLE; word counter and done mask clear to 0. After reset every output is 0: ready_o, conv_start_o, conv_valid_o, conv_yumi_o, valid_o, busy_o, error_o.
- eIDLE:
  - On start_i, drive conv_start_o to all ones for exactly that cycle, clear the counter and mask, and go to eSTREAM.
  - valid_i and yumi_i are ignored.
- eSTREAM:
  - all_ready = &conv_ready_i; ready_o = all_ready.
  - On a transfer (valid_i && all_ready): conv_valid_o is all ones that cycle, otherwise 0. No kernel ever sees a partial broadcast.
  - The counter increments on each transfer. On the transfer with count == FRAME_WORDS-1, go to eWAIT.
- eWAIT:
  - ready_o = 0.
  - Mask bit k is set sticky when conv_valid_i[k] is seen. Bits seen during eSTREAM are also captured.
  - When (mask | conv_valid_i) is all ones, go to eDONE. Latency from the last conv_valid_i to valid_o is 1 cycle.
- eDONE:
  - valid_o = 1.
  - On yumi_i, conv_yumi_o is all ones combinationally in that same cycle; then clear the mask and counter and go to eIDLE.
  - valid_o stays high until yumi_i.
- start_i outside eIDLE is ignored and not queued.
- Back-to-back frames: start_i can be accepted the cycle after the eDONE→eIDLE transition. Minimum frame = 1 + FRAME_WORDS + 1 + 1 cycles plus kernel compute time.
- Reset mid-frame returns to eIDLE within 1 cycle with no stray start, valid or yumi pulse. Kernels are reset by the same reset_i.
- Counter width is $clog2(FRAME_WORDS+1); it never wraps because the state exits at FRAME_WORDS-1.

Optional Feature:
- CONV_SCHED_TIMEOUT_EN defined:
  - A cycle counter runs in eWAIT.
  - If it reaches TIMEOUT_CYCLES before the mask completes, error_o is set sticky until reset_i, and the state forces to eDONE so downstream is not deadlocked.
  - Kernels that have not completed still receive conv_yumi_o.
- Not defined: no counter; error_o is tied to 0; eWAIT waits indefinitely.

Decomposition:
- Shared package conv_sched_pkg holds the state enum typedef and a frame_words(height,width) constant function.
- Natural sub-module: up_counter_enabled for the word counter, instantiated with INPUT_MAX = FRAME_WORDS.
- The watchdog stays inline.

Test Plan:
- Basic frame (NUM_KERNELS=4, height=8, width=2): start_i, then 16 words 1..16 with all ready → 16 broadcast transfers, eWAIT; kernels raise valid on cycles 3,5,5,9 after the last word → valid_o high at the cycle after cycle 9; yumi_i → conv_yumi_o=4'hF, busy_o=0 the next cycle.
- Ready skew: conv_ready_i=4'b1011 for 3 cycles with valid_i=1 → ready_o=0 and conv_valid_o=0 for those cycles; the word transfers on the first all-ready cycle, and the count advances by 1 only.
- Ignored events: start_i pulsed during eSTREAM and yumi_i pulsed during eWAIT → no conv_start_o, no conv_yumi_o, no state change.
- Reset mid-stream after 5 words → eIDLE next cycle, every output 0; a new start_i then streams 16 words from count 0.
- Early done: kernel 2 asserts conv_valid_i during eSTREAM → mask bit 2 is retained; valid_o rises when the other three complete.
- Timeout (CONV_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=20): kernel 3 never completes → error_o=1 and valid_o=1 after 20 eWAIT cycles; error_o stays 1 through later frames until reset_i.
